main_memory: RTL and testbench



---
 rtl/main_memory.sv | 154 +++++++++++++++
 tb/tb_main_memory.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// Line-granular main memory: queues read/write line requests in order and completes
// each one a fixed LATENCY cycles after it starts service.
module main_memory #(
    parameter int unsigned LATENCY   = 5,
    parameter int unsigned LINE_BITS = 10,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         rqst_i,
    input  logic [19:0]  addr_i,
    input  logic         wr_rqst_i,
    input  logic [19:0]  wr_addr_i,
    input  logic [127:0] wr_data_i,
    output logic         data_ready_o,
    output logic [127:0] data_o,
    output logic [19:0]  addr_o,
    output logic         wr_done_o,
    output logic         busy_o
);

    localparam int unsigned PtrW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned Lines   = 2 ** LINE_BITS;
    localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

    typedef struct packed {
        logic         wr;
        logic [15:0]  line;
        logic [127:0] data;
    } entry_t;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    entry_t          q_mem [QDEPTH];
    logic [127:0]    mem_q [Lines];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    state_e          state_q, state_d;
    logic [3:0]      count_q, count_d;
    entry_t          cur_q, cur_d;
    logic            busy_q, busy_d;
    logic            rdy_q, wdone_q;
    logic [127:0]    data_q;
    logic [19:0]     addr_q;

    entry_t wr_ent, rd_ent, in0, in1, enq_a, enq_b;
    logic   wr_v, rd_v, in0_v, in1_v, enq_a_v, enq_b_v;
    logic   q_empty, complete, need_load, load, pop;
    logic [LINE_BITS-1:0] cur_idx;
    logic   unused_lsbs;

    assign unused_lsbs = ^{addr_i[3:0], wr_addr_i[3:0]};
    assign cur_idx     = cur_q.line[LINE_BITS-1:0];

    // Write is ordered ahead of a simultaneous read so the read sees the new data.
    always_comb begin
        wr_ent    = {1'b1, wr_addr_i[19:4], wr_data_i};
        rd_ent    = {1'b0, addr_i[19:4], 128'h0};
        wr_v      = wr_rqst_i && !busy_q;
        rd_v      = rqst_i && !busy_q;
        in0_v     = wr_v || rd_v;
        in0       = wr_v ? wr_ent : rd_ent;
        in1_v     = wr_v && rd_v;
        in1       = rd_ent;
        q_empty   = (cnt_q == '0);
        complete  = (state_q == StBusy) && (count_q == 4'd0);
        need_load = (state_q == StIdle) || complete;
        load      = need_load && (!q_empty || in0_v);
        pop       = load && !q_empty;

        enq_a_v = in0_v;
        enq_a   = in0;
        enq_b_v = in1_v;
        enq_b   = in1;
        if (load && q_empty) begin
            // Bypass: the first incoming entry goes straight to the engine.
            enq_a_v = in1_v;
            enq_a   = in1;
            enq_b_v = 1'b0;
        end

        state_d = state_q;
        count_d = count_q;
        cur_d   = cur_q;
        if (state_q == StBusy && count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
        if (need_load) begin
            if (load) begin
                state_d = StBusy;
                count_d = LoadCnt;
                cur_d   = pop ? q_mem[rd_ptr_q] : in0;
            end else begin
                state_d = StIdle;
            end
        end

        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(enq_a_v) + PtrW'(enq_b_v);
        cnt_d    = cnt_q + CntW'(enq_a_v) + CntW'(enq_b_v) - CntW'(pop);
        busy_d   = (32'(cnt_d) + 32'd2) > QDEPTH;
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= StIdle;
            count_q  <= 4'd0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
            wdone_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            count_q  <= count_d;
            cur_q    <= cur_d;
            busy_q   <= busy_d;
            rdy_q    <= complete && !cur_q.wr;
            wdone_q  <= complete && cur_q.wr;
            if (complete && !cur_q.wr) begin
                data_q <= mem_q[cur_idx];
                addr_q <= {cur_q.line, 4'h0};
            end
        end
    end

    // Storage is deliberately unreset; contents survive rsn_i.
    always_ff @(posedge clk_i) begin
        if (!rsn_i && complete && cur_q.wr) begin
            mem_q[cur_idx] <= cur_q.data;
        end
        if (enq_a_v) begin
            q_mem[wr_ptr_q] <= enq_a;
        end
        if (enq_b_v) begin
            q_mem[wr_ptr_q + PtrW'(1)] <= enq_b;
        end
    end

    assign data_ready_o = rdy_q;
    assign wr_done_o    = wdone_q;
    assign data_o       = data_q;
    assign addr_o       = addr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: transaction-level model checked every cycle on a LATENCY=5
// instance, plus directed literal checks on it and on a LATENCY=1 instance.
module tb_main_memory;

    localparam int unsigned L5 = 5;
    localparam int unsigned QD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         rqst = 1'b0, wr = 1'b0;
    logic [19:0]  addr = '0, waddr = '0;
    logic [127:0] wdata = '0;
    logic         rdy, wd, busy;
    logic [127:0] data;
    logic [19:0]  aout;

    logic         rqst1 = 1'b0, wr1 = 1'b0;
    logic [19:0]  addr1 = '0, waddr1 = '0;
    logic [127:0] wdata1 = '0;
    logic         rdy1, wd1, busy1;
    logic [127:0] data1;
    logic [19:0]  aout1;

    main_memory #(.LATENCY(5), .LINE_BITS(10), .QDEPTH(4)) dut (
        .clk_i(clk), .rsn_i(rst), .rqst_i(rqst), .addr_i(addr), .wr_rqst_i(wr),
        .wr_addr_i(waddr), .wr_data_i(wdata), .data_ready_o(rdy), .data_o(data),
        .addr_o(aout), .wr_done_o(wd), .busy_o(busy)
    );

    main_memory #(.LATENCY(1), .LINE_BITS(10), .QDEPTH(4)) dut1 (
        .clk_i(clk), .rsn_i(rst), .rqst_i(rqst1), .addr_i(addr1), .wr_rqst_i(wr1),
        .wr_addr_i(waddr1), .wr_data_i(wdata1), .data_ready_o(rdy1), .data_o(data1),
        .addr_o(aout1), .wr_done_o(wd1), .busy_o(busy1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: each accepted op starts when the previous one completes (or on arrival if
    // the engine is free) and completes L5 edges later; queued = accepted but not started.
    typedef struct {
        bit           w;
        logic [19:0]  a;
        logic [127:0] d;
        longint       start;
        longint       comp;
    } op_t;

    op_t          ops[$];
    logic [127:0] mmem [1024];
    longint       t = 0;
    longint       last_comp = 0;
    logic         e_rdy = 1'b0, e_wd = 1'b0, e_busy = 1'b0;
    logic [127:0] e_data = '0;
    logic [19:0]  e_addr = '0;

    function automatic void add_op(input bit w, input logic [19:0] a, input logic [127:0] d);
        op_t o;
        o.w     = w;
        o.a     = a;
        o.d     = d;
        o.start = (last_comp > t) ? last_comp : t;
        o.comp  = o.start + L5;
        last_comp = o.comp;
        ops.push_back(o);
    endfunction

    always @(posedge clk) begin
        op_t o;
        int  idx;
        int  occ;
        bit  bprev;
        t++;
        if (rst) begin
            ops.delete();
            e_rdy = 0; e_wd = 0; e_busy = 0; e_data = '0; e_addr = '0;
            last_comp = t;
        end else begin
            bprev = e_busy;
            e_rdy = 0;
            e_wd  = 0;
            if (ops.size() > 0 && ops[0].comp == t) begin
                o   = ops.pop_front();
                idx = int'(o.a >> 4) % 1024;
                if (o.w) begin
                    mmem[idx] = o.d;
                    e_wd = 1;
                end else begin
                    e_rdy  = 1;
                    e_data = mmem[idx];
                    e_addr = {o.a[19:4], 4'h0};
                end
            end
            if (!bprev && wr)   add_op(1'b1, waddr, wdata);
            if (!bprev && rqst) add_op(1'b0, addr, '0);
            occ = 0;
            foreach (ops[i]) if (ops[i].start > t) occ++;
            e_busy = (occ >= int'(QD) - 1);
        end
        #1;
        check("model data_ready", rdy, e_rdy);
        check("model wr_done", wd, e_wd);
        check("model busy", busy, e_busy);
        check("model data", data, e_data);
        check("model addr", aout, e_addr);
    end

    logic [127:0] pre [32];

    function automatic logic [127:0] rdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [19:0] raddr();
        return {6'($urandom), 5'b0, 5'($urandom_range(0, 31)), 4'($urandom)};
    endfunction

    initial begin
        logic [127:0] d1, d2, d3, d4, d5;
        int guard;
        d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        d2 = 128'hFEDCBA98765432100011223344556677;
        d3 = 128'hA5A5A5A55A5A5A5ADEADBEEFCAFEF00D;
        d4 = 128'h11111111222222223333333344444444;
        d5 = 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC;

        tick(); tick();
        check("reset data_ready", rdy, 0);
        check("reset data", data, 0);
        check("reset addr", aout, 0);
        check("reset wr_done", wd, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;

        // Prefill lines 0..31 so every later read hits defined data.
        for (int i = 0; i < 32; i++) begin
            guard = 0;
            while (e_busy && guard < 100) begin tick(); guard++; end
            pre[i] = rdata();
            wr = 1'b1;
            waddr = {6'($urandom), 5'b0, 5'(i), 4'($urandom)};
            wdata = pre[i];
            tick();
            wr = 1'b0;
        end
        repeat (40) tick();

        // Write then read, same line with different byte offset.
        wr = 1'b1; waddr = 20'h000A0; wdata = d1;
        tick();
        wr = 1'b0;
        repeat (4) tick();
        check("wr_done before +5", wd, 0);
        tick();
        check("wr_done at +5", wd, 1);
        rqst = 1'b1; addr = 20'h000AC;
        tick();
        rqst = 1'b0;
        repeat (4) tick();
        check("read not early", rdy, 0);
        tick();
        check("read ready at +5", rdy, 1);
        check("read data", data, d1);
        check("read addr aligned", aout, 20'h000A0);

        // Simultaneous write + read of one line.
        repeat (10) tick();
        wr = 1'b1; waddr = 20'h00100; wdata = d2; rqst = 1'b1; addr = 20'h00100;
        tick();
        wr = 1'b0; rqst = 1'b0;
        repeat (5) tick();
        check("pair wr_done", wd, 1);
        check("pair no rdy with wr_done", rdy, 0);
        repeat (5) tick();
        check("pair rdy at +10", rdy, 1);
        check("pair data new", data, d2);
        check("pair addr", aout, 20'h00100);

        // Six consecutive reads: four fit, the last two are dropped while busy.
        repeat (40) tick();
        for (int i = 0; i < 6; i++) begin
            rqst = 1'b1; addr = {16'(i), 4'h0};
            tick();
            if (i == 2) check("busy low with 2 queued", busy, 0);
            if (i == 3) check("busy high with 3 queued", busy, 1);
        end
        rqst = 1'b0;
        check("burst first rdy", rdy, 1);
        check("burst first addr", aout, 20'h00000);
        check("burst first data", data, pre[0]);
        for (int j = 1; j < 4; j++) begin
            repeat (4) tick();
            check("burst gap no rdy", rdy, 0);
            tick();
            check("burst rdy", rdy, 1);
            check("burst addr", aout, {16'(j), 4'h0});
            check("burst data", data, pre[j]);
        end
        repeat (5) tick();
        check("dropped read absent", rdy, 0);

        // Aliasing: address bits above the line index are ignored.
        repeat (40) tick();
        wr = 1'b1; waddr = 20'h40010; wdata = d3;
        tick();
        wr = 1'b0;
        repeat (5) tick();
        rqst = 1'b1; addr = 20'h00010;
        tick();
        rqst = 1'b0;
        repeat (5) tick();
        check("alias rdy", rdy, 1);
        check("alias data", data, d3);
        check("alias addr", aout, 20'h00010);

        // Reset during an in-flight read.
        repeat (40) tick();
        rqst = 1'b1; addr = 20'h00020;
        tick();
        rqst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset data", data, 0);
        check("midreset addr", aout, 0);
        check("midreset busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("no rdy after reset", rdy, 0);
        end
        rqst = 1'b1; addr = 20'h00020;
        tick();
        rqst = 1'b0;
        repeat (5) tick();
        check("post-reset rdy", rdy, 1);
        check("post-reset data kept", data, pre[2]);

        // Random traffic with occasional protocol violations and resets.
        repeat (40) tick();
        for (int c = 0; c < 800; c++) begin
            bit can;
            rst   = ($urandom_range(0, 299) == 0);
            can   = !e_busy || ($urandom_range(0, 9) == 0);
            wr    = can && ($urandom_range(0, 2) == 0);
            rqst  = can && ($urandom_range(0, 2) == 0);
            waddr = raddr();
            wdata = rdata();
            addr  = raddr();
            tick();
        end
        rst = 1'b0; wr = 1'b0; rqst = 1'b0;
        repeat (40) tick();

        // LATENCY=1 instance.
        wr1 = 1'b1; waddr1 = 20'h00030; wdata1 = d4;
        tick();
        wr1 = 1'b0;
        check("L1 wr_done not same edge", wd1, 0);
        tick();
        check("L1 wr_done", wd1, 1);
        wr1 = 1'b1; waddr1 = 20'h00040; wdata1 = d5;
        tick();
        wr1 = 1'b0;
        tick();
        rqst1 = 1'b1; addr1 = 20'h00038;
        tick();
        check("L1 rdy not same edge", rdy1, 0);
        addr1 = 20'h00040;
        tick();
        rqst1 = 1'b0;
        check("L1 rdy A", rdy1, 1);
        check("L1 data A", data1, d4);
        check("L1 addr A", aout1, 20'h00030);
        rqst1 = 1'b1; addr1 = 20'h00030;
        tick();
        rqst1 = 1'b0;
        check("L1 rdy B back-to-back", rdy1, 1);
        check("L1 data B", data1, d5);
        check("L1 addr B", aout1, 20'h00040);
        tick();
        check("L1 rdy C", rdy1, 1);
        check("L1 data C", data1, d4);
        tick();
        check("L1 rdy low", rdy1, 0);
        check("L1 busy", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
